spi_sd_master: RTL and testbench

CPU-mapped SPI master that drives the SD card interface (`sd_cs`, `spi_clk`, `spi_mosi`, `spi_miso`) of the super6502 top level. It sits directly upstream of the SD card and is reached by the 65C02 through a 4-byte register window decoded elsewhere. Each byte transfer is SPI mode 0, MSB first, with a programmable SCLK divider and a software-driven chip select. Transfer state is exposed through busy, done and overrun flags.

---
 rtl/spi_sd_master_pkg.sv | 13 +
 rtl/spi_shift_core.sv | 74 +++++++
 rtl/spi_sd_master.sv | 93 +++++++++
 tb/tb_spi_sd_master.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_sd_master_pkg.sv
// spi_sd_master_pkg: register map, STAT bit positions, divider default and transfer state for spi_sd_master.
package spi_sd_master_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_CS   = 2'd3;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_IE   = 3;
  localparam logic [7:0] DIV_RESET_DEFAULT = 8'd49;
  typedef enum logic {ST_IDLE, ST_XFER} state_e;
endpackage

// File: rtl/spi_shift_core.sv
// spi_shift_core: mode-0 MSB-first byte engine with per-transfer latched SCLK half-period divider.
module spi_shift_core import spi_sd_master_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic [7:0] i_div,
  input  logic       i_miso,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rx,
  output logic       o_sclk,
  output logic       o_mosi
);
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, div_q, div_d, tx_q, tx_d, rx_q, rx_d;
  logic [3:0] tgl_q, tgl_d;
  logic       sclk_q, sclk_d, tick;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      tx_q    <= '1;
      rx_q    <= '0;
      tgl_q   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      tgl_q   <= tgl_d;
      sclk_q  <= sclk_d;
    end
  end
  // MOSI is tx_q[7]; ones are shifted in behind the data so the line idles high after the last bit.
  always_comb begin
    tick    = cnt_q == 8'd0;
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    tgl_d   = tgl_q;
    sclk_d  = sclk_q;
    if (state_q == ST_IDLE) begin
      if (i_start) begin
        state_d = ST_XFER;
        cnt_d   = i_div;
        div_d   = i_div;
        tx_d    = i_tx;
        tgl_d   = '0;
      end
    end else if (tick) begin
      cnt_d  = div_q;
      sclk_d = ~sclk_q;
      tgl_d  = tgl_q + 4'd1;
      if (tgl_q[0]) tx_d = {tx_q[6:0], 1'b1};
      else rx_d = {rx_q[6:0], i_miso};
      if (tgl_q == 4'd15) state_d = ST_IDLE;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end
  always_comb begin
    o_busy = state_q == ST_XFER;
    o_done = o_busy && tick && tgl_q == 4'd15;
    o_rx   = rx_q;
    o_sclk = sclk_q;
    o_mosi = tx_q[7];
  end
endmodule

// File: rtl/spi_sd_master.sv
// spi_sd_master: CPU-mapped SD-card SPI master (DATA/STAT/DIV/CS registers, busy/done/overrun flags).
// Define SPI_SD_MASTER_IRQ_EN to add the IE bit and the o_irq level interrupt.
module spi_sd_master import spi_sd_master_pkg::*; #(
  parameter logic [7:0] DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_sd_cs,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso
`ifdef SPI_SD_MASTER_IRQ_EN
  ,output logic      o_irq
`endif
);
  logic       wr_data, wr_stat, wr_div, wr_cs, rd_data, start, busy, core_done, ie;
  logic [7:0] core_rx, rx_q, rx_d, div_q, div_d, stat;
  logic       done_q, done_d, ovr_q, ovr_d, cs_q, cs_d;
  always_comb begin
    wr_data = i_wr && i_addr == ADDR_DATA;
    wr_stat = i_wr && i_addr == ADDR_STAT;
    wr_div  = i_wr && i_addr == ADDR_DIV;
    wr_cs   = i_wr && i_addr == ADDR_CS;
    rd_data = i_rd && i_addr == ADDR_DATA;
    start   = wr_data && !busy;
  end
  spi_shift_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_tx    (i_data),
    .i_div   (div_q),
    .i_miso  (i_spi_miso),
    .o_busy  (busy),
    .o_done  (core_done),
    .o_rx    (core_rx),
    .o_sclk  (o_spi_clk),
    .o_mosi  (o_spi_mosi)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q   <= '0;
      div_q  <= DIV_RESET;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      rx_q   <= rx_d;
      div_q  <= div_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      cs_q   <= cs_d;
    end
  end
  // A completing byte wins over a same-cycle DATA read; an OVR clear wins over a same-cycle overrun.
  always_comb begin
    rx_d   = core_done ? core_rx : rx_q;
    div_d  = wr_div ? i_data : div_q;
    done_d = core_done ? 1'b1 : rd_data ? 1'b0 : done_q;
    ovr_d  = (wr_stat && i_data[STAT_OVR]) ? 1'b0 : (wr_data && busy) ? 1'b1 : ovr_q;
    cs_d   = wr_cs ? i_data[0] : cs_q;
  end
`ifdef SPI_SD_MASTER_IRQ_EN
  logic ie_q, ie_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ie_q <= 1'b0;
    else ie_q <= ie_d;
  end
  always_comb begin
    ie_d  = wr_stat ? i_data[STAT_IE] : ie_q;
    ie    = ie_q;
    o_irq = ie_q && done_q;
  end
`else
  always_comb ie = 1'b0;
`endif
  always_comb begin
    stat            = '0;
    stat[STAT_BUSY] = busy;
    stat[STAT_DONE] = done_q;
    stat[STAT_OVR]  = ovr_q;
    stat[STAT_IE]   = ie;
    o_sd_cs         = cs_q;
    o_data          = i_addr == ADDR_DATA ? rx_q :
                      i_addr == ADDR_STAT ? stat :
                      i_addr == ADDR_DIV  ? div_q : {7'b0, cs_q};
  end
endmodule

// File: tb/tb_spi_sd_master.sv
// tb_spi_sd_master: randomized scoreboard bench; a bus monitor checks every byte on MOSI and SCLK timing.
module tb_spi_sd_master;
  typedef struct {
    logic [7:0] tx;
    int         half;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0, i_wr = 1'b0, i_rd = 1'b0;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_data = 8'd0, o_data, acc = 8'd0, slave_byte = 8'd0;
  logic       o_sd_cs, o_spi_clk, o_spi_mosi, i_spi_miso, prev = 1'b0;
`ifdef SPI_SD_MASTER_IRQ_EN
  logic       o_irq;
`endif
  int   pass_cnt = 0, total = 0, nbits = 0, run = 0;
  bit   ie_exp = 1'b0;
  exp_t exp_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  spi_sd_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr       (i_wr),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_data     (i_data),
    .o_data     (o_data),
    .o_sd_cs    (o_sd_cs),
    .o_spi_clk  (o_spi_clk),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso)
`ifdef SPI_SD_MASTER_IRQ_EN
    ,.o_irq     (o_irq)
`endif
  );

  // SD-card model: presents bit (7 - bits already clocked) of slave_byte, MSB first.
  assign i_spi_miso = (nbits < 8) ? slave_byte[3'd7 - nbits[2:0]] : 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      run   = 0;
      prev  = 1'b0;
      exp_q.delete();
    end else begin
      if (o_spi_clk && !prev) begin
        if (nbits == 0) begin
          if (exp_q.size() == 0) chk("unexpected_sclk", 1, 0);
          else cur = exp_q.pop_front();
        end else chk("sclk_low_width", run, cur.half);
        acc   = {acc[6:0], o_spi_mosi};
        nbits = nbits + 1;
        run   = 1;
      end else if (!o_spi_clk && prev) begin
        chk("sclk_high_width", run, cur.half);
        run = 1;
        if (nbits == 8) begin
          chk("mosi_byte", acc, cur.tx);
          nbits = 0;
        end
      end else run = run + 1;
      prev = o_spi_clk;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    i_wr = 1'b1; i_addr = a; i_data = d;
    @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    i_addr = a;
    #1 d = o_data;
  endtask

  task automatic rd_strobe(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    i_addr = a; i_rd = 1'b1;
    #1 d = o_data;
    @(negedge clk);
    i_rd = 1'b0;
  endtask

  // One byte: expected MOSI byte/half-period go to the monitor; BUSY length, flags and RX are checked here.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input int div, input int ovr_at);
    int cnt;
    bit ovr;
    logic [7:0] d;
    wr(2'd2, div[7:0]);
    exp_q.push_back('{tx, div + 1});
    slave_byte = sb;
    wr(2'd0, tx);
    cnt = 0; ovr = 1'b0; i_addr = 2'd1;
    #1;
    while (o_data[0] && cnt < 5000) begin
      cnt++;
      if (cnt == ovr_at) begin
        i_wr = 1'b1; i_addr = 2'd0; i_data = 8'h11; ovr = 1'b1;
      end
      @(negedge clk);
      i_wr = 1'b0; i_addr = 2'd1;
      #1;
    end
    chk("busy_cycles", cnt, 16 * (div + 1));
    chk("stat_done", o_data, {4'b0, ie_exp, ovr, 2'b10});
`ifdef SPI_SD_MASTER_IRQ_EN
    chk("irq_with_done", o_irq, ie_exp);
`endif
    rd_strobe(2'd0, d);
    chk("rx_byte", d, sb);
    peek(2'd1, d);
    chk("stat_after_read", d, {4'b0, ie_exp, ovr, 2'b00});
`ifdef SPI_SD_MASTER_IRQ_EN
    chk("irq_after_read", o_irq, 0);
`endif
    if (ovr) begin
      wr(2'd1, {4'b0, ie_exp, 3'b100});
      peek(2'd1, d);
      chk("ovr_clear", d, {4'b0, ie_exp, 3'b000});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cs", o_sd_cs, 1);
    chk("rst_sclk", o_spi_clk, 0);
    chk("rst_mosi", o_spi_mosi, 1);
    peek(2'd1, d); chk("rst_stat", d, 8'h00);
    peek(2'd2, d); chk("rst_div", d, 49);
    peek(2'd0, d); chk("rst_rx", d, 8'h00);
    peek(2'd3, d); chk("rst_cs_reg", d, 8'h01);

    wr(2'd3, 8'h00);
    peek(2'd3, d); chk("cs_low", o_sd_cs, 0);
    xfer(8'hA5, 8'h3C, 0, -1);
    xfer(8'hFF, 8'($urandom), 3, -1);
    xfer(8'h5A, 8'($urandom), 1, 5);
    for (int i = 0; i < 5; i++) xfer(8'($urandom), 8'($urandom), $urandom_range(0, 3), -1);

    wr(2'd2, 8'd1);
    exp_q.push_back('{8'hC3, 2});
    slave_byte = 8'($urandom);
    wr(2'd0, 8'hC3);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", o_sd_cs, 1);
    chk("abort_sclk", o_spi_clk, 0);
    chk("abort_mosi", o_spi_mosi, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    peek(2'd1, d); chk("abort_stat", d, 8'h00);
    peek(2'd0, d); chk("abort_rx", d, 8'h00);
    peek(2'd2, d); chk("abort_div", d, 49);
    wr(2'd3, 8'h00);
    xfer(8'h96, 8'($urandom), 2, -1);

`ifdef SPI_SD_MASTER_IRQ_EN
    wr(2'd1, 8'h08);
    ie_exp = 1'b1;
    peek(2'd1, d); chk("ie_set", d, 8'h08);
    xfer(8'($urandom), 8'($urandom), 1, -1);
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
